// File: rtl/fp_pkg.sv
// Shared widths and types for the single-precision adder post-add stage.
package fp_pkg;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp_word_t;

  // Normalized beat between the normalize and round/pack stages.
  typedef struct packed {
    logic                    sign;
    logic                    zero;
    logic signed [EXP_W+1:0] exp;
    logic                    hidden;
    logic [MAN_W-1:0]        frac;
    logic                    guard;
    logic                    sticky;
  } norm_beat_t;
endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero vector reports W.
module fp_lzc #(
  parameter int unsigned W     = 25,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     vec,
  output logic [CNT_W-1:0] count
);
  always_comb begin
    count = CNT_W'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (vec[i]) count = CNT_W'(W - 1 - i);
    end
  end
endmodule

// File: rtl/fp_normalize_round.sv
// Post-add normalize, round-to-nearest-even and pack, as a two-stage
// valid/ready pipeline between the mantissa adder and the result register.
module fp_normalize_round #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [EXP_W-1:0]   in_exp,
  input  logic [MAN_W+3:0]   in_mant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic               out_overflow,
  output logic               out_underflow
);
  import fp_pkg::*;

  localparam int unsigned NORM_W = MAN_W + 2;
  localparam int unsigned LZ_W   = $clog2(NORM_W + 1);
  localparam logic signed [EXP_W+1:0] EXP_TOP = (EXP_W + 2)'(EXP_MAX);

  norm_beat_t              s1_next, s1;
  logic                    s1_valid, s2_advance;
  logic [NORM_W-1:0]       norm_vec, norm_shift;
  logic [LZ_W-1:0]         lz;
  logic signed [EXP_W+1:0] exp_ext;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = rst_n && (!s1_valid || s2_advance);
  assign norm_vec   = in_mant[MAN_W+2:1];
  assign exp_ext    = signed'({2'b00, in_exp});
  assign norm_shift = norm_vec << lz;

  fp_lzc #(.W(NORM_W)) u_lzc (.vec(norm_vec), .count(lz));

  always_comb begin
    s1_next      = '0;
    s1_next.sign = in_sign;
    if (in_mant == '0) begin
      s1_next.zero = 1'b1;
    end else if (in_mant[MAN_W+3]) begin
      s1_next.exp = exp_ext + (EXP_W + 2)'(1);
      {s1_next.hidden, s1_next.frac, s1_next.guard} = in_mant[MAN_W+3:2];
      s1_next.sticky = in_mant[1] | in_mant[0];
    end else if (in_mant[MAN_W+2]) begin
      s1_next.exp = exp_ext;
      {s1_next.hidden, s1_next.frac, s1_next.guard, s1_next.sticky} = in_mant[MAN_W+2:0];
    end else begin
      {s1_next.hidden, s1_next.frac, s1_next.guard} = norm_shift;
      s1_next.sticky = in_mant[0];
      s1_next.exp    = exp_ext - signed'({{(EXP_W + 2 - LZ_W){1'b0}}, lz});
    end
  end

  logic                    round_up, man_carry;
  logic [MAN_W:0]          frac_sum;
  logic signed [EXP_W+1:0] exp_r;
  fp_word_t                res_next;
  logic                    ovf_next, unf_next;

  // Hidden is always set on a normalized beat, so a fraction carry means
  // the significand rolled over to the next binade.
  assign round_up  = s1.guard & (s1.sticky | s1.frac[0]);
  assign frac_sum  = {1'b0, s1.frac} + (MAN_W + 1)'(round_up);
  assign man_carry = frac_sum[MAN_W] & s1.hidden;
  assign exp_r     = s1.exp + (EXP_W + 2)'(man_carry);

  always_comb begin
    res_next = '0;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (!s1.zero) begin
      // Hidden clear here means only sticky survived: nothing representable.
      if (!s1.hidden || exp_r[EXP_W+1] || exp_r == '0) begin
        res_next.sign = s1.sign;
        unf_next      = 1'b1;
      end else if (exp_r >= EXP_TOP) begin
        res_next.sign = s1.sign;
        res_next.exp  = '1;
        ovf_next      = 1'b1;
      end else begin
        res_next.sign = s1.sign;
        res_next.exp  = exp_r[EXP_W-1:0];
        res_next.frac = frac_sum[MAN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1            <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1       <= s1_next;
      end else if (s2_advance) begin
        s1_valid <= 1'b0;
      end
      if (s2_advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result    <= res_next;
          out_overflow  <= ovf_next;
          out_underflow <= unf_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: directed vectors plus randomized traffic
// checked through an in-order scoreboard against a value-level model.
module tb_fp_normalize_round;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [26:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  fp_normalize_round #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_underflow(out_underflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Value-level model: locate the leading one of the significant bits,
  // keep 24 bits, round to nearest even, then classify the exponent.
  function automatic logic [33:0] ref_model(input logic s, input logic [7:0] e_in, input logic [26:0] m);
    logic [25:0] sig;
    logic [26:0] keep;
    int p, e, sh;
    logic g, st;
    if (m == '0) return 34'h0;
    sig = m[26:1];
    if (sig == '0) return {2'b01, s, 31'h0};
    p = 25;
    while (!sig[p]) p--;
    e = int'(e_in) + p - 24;
    if (p >= 24) begin
      sh   = p - 23;
      keep = 27'(sig >> sh);
      g    = sig[sh-1];
      st   = m[0] || ((sig & ((26'd1 << (sh - 1)) - 26'd1)) != '0);
    end else begin
      keep = 27'(sig) << (23 - p);
      g    = 1'b0;
      st   = m[0];
    end
    if (g && (st || keep[0])) keep = keep + 27'd1;
    if (keep == 27'h1000000) begin
      keep = keep >> 1;
      e++;
    end
    if (e <= 0)   return {2'b01, s, 31'h0};
    if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
    return {2'b00, s, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [26:0] rand_mant();
    case ($urandom_range(0, 4))
      0:       return 27'($urandom);
      1:       return {2'b01, 25'($urandom)};
      2:       return 27'($urandom) >> $urandom_range(0, 26);
      3:       return 27'($urandom_range(0, 1));
      default: return {1'b1, 26'($urandom)};
    endcase
  endfunction

  logic        held = 1'b0;
  logic [34:0] held_val = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) check("hold", {out_valid, out_overflow, out_underflow, out_result}, held_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else check("beat", {out_overflow, out_underflow, out_result}, exp_q.pop_front());
      end
      held     = out_valid && !out_ready;
      held_val = {out_valid, out_overflow, out_underflow, out_result};
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [26:0] m, input logic [33:0] want);
    int n = 0;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 0, 1);
    else exp_q.push_back(want);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic s;
    logic [7:0] e;
    logic [26:0] m;
    s = 1'($urandom);
    e = 8'($urandom_range(0, 254));
    m = rand_mant();
    send(s, e, m, ref_model(s, e, m));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic latency_probe(input string tag);
    send(1'b1, 8'h85, 27'h2000000, {2'b00, 32'hC2800000});
    @(negedge clk);
    check({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat2"}, out_valid, 1);
    drain();
  endtask

  initial begin
    bit done;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_flags", {out_overflow, out_underflow}, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1);

    latency_probe("first");

    send(1'b0, 8'h80, 27'h4000000, {2'b00, 32'h40800000});
    send(1'b0, 8'h7F, 27'h1000000, {2'b00, 32'h3F000000});
    send(1'b1, 8'h7F, 27'h0000000, {2'b00, 32'h00000000});
    send(1'b0, 8'h7F, 27'h2000006, {2'b00, 32'h3F800002});
    send(1'b0, 8'h7F, 27'h2000002, {2'b00, 32'h3F800000});
    send(1'b0, 8'h7F, 27'h2000003, {2'b00, 32'h3F800001});
    send(1'b0, 8'hFE, 27'h4000000, {2'b10, 32'h7F800000});
    send(1'b0, 8'h01, 27'h0800000, {2'b01, 32'h00000000});
    send(1'b0, 8'hFE, 27'h3FFFFFE, {2'b10, 32'h7F800000});
    send(1'b1, 8'h00, 27'h2000000, {2'b01, 32'h80000000});
    drain();

    fork
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        send_rand();
        send_rand();
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        send_rand();
        send_rand();
      end
    join
    drain();

    send_rand();
    send_rand();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;
    latency_probe("post_rst");

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_rand();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
